start_stretch_mc: RTL and testbench

START_STRETCH_MC -- requirements
Module: start_stretch_mc

---
 rtl/phy_ctrl_pkg.sv | 26 ++
 rtl/start_stretch_ch.sv | 94 +++++++++
 rtl/start_stretch_mc.sv | 48 ++++
 tb/tb_start_stretch_mc.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/phy_ctrl_pkg.sv
// Shared encodings for the start-stretch channels: trigger edge select and per-channel FSM state.
package phy_ctrl_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACTIVE  = 2'b01,
        ST_HOLDOFF = 2'b10
    } ch_state_e;

    function automatic logic edge_hit(input logic cur, input logic prev, input logic [1:0] sel);
        case (sel)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            EDGE_BOTH: return cur ^ prev;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/start_stretch_ch.sv
// One start channel: edge detection on start_in, IDLE/ACTIVE/HOLDOFF FSM and
// a saturating length counter producing a registered stretched pulse and done strobe.
module start_stretch_ch
    import phy_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned HOLDOFF_CYC = 0,
    parameter int unsigned RETRIG      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [1:0]       edge_sel,
    input  logic [CNT_W-1:0] stretch_len,
    output logic             start_out,
    output logic             done,
    output logic             busy_next
);

    localparam int unsigned HO_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC + 1) : 1;

    ch_state_e        state, state_next;
    logic             prev;
    logic             trig;
    logic             done_next;
    logic [CNT_W-1:0] cnt, cnt_next, len_eff;
    logic [HO_W-1:0]  ho_cnt, ho_next;

    assign trig    = edge_hit(start_in, prev, edge_sel);
    assign len_eff = (stretch_len == '0) ? CNT_W'(1) : stretch_len;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ho_next    = ho_cnt;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_next = ST_ACTIVE;
                    cnt_next   = len_eff;
                end
            end
            ST_ACTIVE: begin
                // A retrigger wins over the terminal count, so the pulse never drops for a cycle.
                if (trig && (RETRIG != 0)) begin
                    cnt_next = len_eff;
                end else if (cnt <= CNT_W'(1)) begin
                    cnt_next  = '0;
                    done_next = 1'b1;
                    if (HOLDOFF_CYC > 0) begin
                        state_next = ST_HOLDOFF;
                        ho_next    = HO_W'(HOLDOFF_CYC);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (ho_cnt <= HO_W'(1)) begin
                    state_next = ST_IDLE;
                    ho_next    = '0;
                end else begin
                    ho_next = ho_cnt - HO_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Lets the top register busy in the same cycle the state itself changes.
    assign busy_next = (state_next != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ho_cnt    <= '0;
            prev      <= 1'b0;
            start_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            ho_cnt    <= ho_next;
            prev      <= start_in;
            start_out <= (state_next == ST_ACTIVE);
            done      <= done_next;
        end
    end

endmodule

// File: rtl/start_stretch_mc.sv
// Multi-channel start stretcher: NUM_CH independent channels plus a registered
// busy flag that is high whenever any channel is outside IDLE.
module start_stretch_mc
    import phy_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned HOLDOFF_CYC = 0,
    parameter int unsigned RETRIG      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] start_in,
    input  logic [1:0]        edge_sel,
    input  logic [CNT_W-1:0]  stretch_len,
    output logic [NUM_CH-1:0] start_out,
    output logic [NUM_CH-1:0] done,
    output logic              busy
);

    logic [NUM_CH-1:0] busy_next;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        start_stretch_ch #(
            .CNT_W      (CNT_W),
            .HOLDOFF_CYC(HOLDOFF_CYC),
            .RETRIG     (RETRIG)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .start_in   (start_in[g]),
            .edge_sel   (edge_sel),
            .stretch_len(stretch_len),
            .start_out  (start_out[g]),
            .done       (done[g]),
            .busy_next  (busy_next[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= |busy_next;
        end
    end

endmodule

// File: tb/tb_start_stretch_mc.sv
// Directed bench for start_stretch_mc: default, retrigger and holdoff configurations
// driven from shared inputs, checked against hand-computed expectations.
module tb_start_stretch_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start_in;
    logic [1:0] edge_sel;
    logic [5:0] stretch_len;

    logic [3:0] out_a, done_a, out_r, done_r, out_h, done_h;
    logic       busy_a, busy_r, busy_h;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    start_stretch_mc #(.NUM_CH(4), .CNT_W(6), .HOLDOFF_CYC(0), .RETRIG(0)) dut_a (
        .clk(clk), .rst(rst), .start_in(start_in), .edge_sel(edge_sel),
        .stretch_len(stretch_len), .start_out(out_a), .done(done_a), .busy(busy_a));

    start_stretch_mc #(.NUM_CH(4), .CNT_W(6), .HOLDOFF_CYC(0), .RETRIG(1)) dut_r (
        .clk(clk), .rst(rst), .start_in(start_in), .edge_sel(edge_sel),
        .stretch_len(stretch_len), .start_out(out_r), .done(done_r), .busy(busy_r));

    start_stretch_mc #(.NUM_CH(4), .CNT_W(6), .HOLDOFF_CYC(3), .RETRIG(0)) dut_h (
        .clk(clk), .rst(rst), .start_in(start_in), .edge_sel(edge_sel),
        .stretch_len(stretch_len), .start_out(out_h), .done(done_h), .busy(busy_h));

    typedef struct {
        logic       rst;
        logic [3:0] sin;
        logic [1:0] esel;
        logic [5:0] len;
        logic [3:0] out;
        logic [3:0] dn;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] s, input logic [1:0] e,
                                input logic [5:0] l, input logic [3:0] o, input logic [3:0] d,
                                input logic b);
        vec_t t;
        t.rst = r; t.sin = s; t.esel = e; t.len = l; t.out = o; t.dn = d; t.bsy = b;
        return t;
    endfunction

    // Inputs are applied 1 time unit after an edge, outputs sampled 1 unit after the next.
    task automatic drive(input logic r, input logic [3:0] s, input logic [1:0] e, input logic [5:0] l);
        rst = r; start_in = s; edge_sel = e; stretch_len = l;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got out=%b done=%b busy=%b, expected out=%b done=%b busy=%b",
                     name, idx, act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    initial begin
        logic [12:0] hpat;
        rst = 1'b1; start_in = '0; edge_sel = 2'b00; stretch_len = 6'd6;
        #1;

        // reset
        tbl.push_back(mk(1'b1, 4'h0, 2'd0, 6'd6, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h0, 2'd0, 6'd6, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 2'd0, 6'd6, 4'h0, 4'h0, 1'b0));
        // ch0 rising edge, L=6
        tbl.push_back(mk(1'b0, 4'h1, 2'd0, 6'd6, 4'h1, 4'h0, 1'b1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b0, 4'h1, 2'd0, 6'd6, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h1, 2'd0, 6'd6, 4'h0, 4'h1, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 2'd0, 6'd6, 4'h0, 4'h0, 1'b0));
        // both edges on ch2, L=2: falling edge lands in IDLE
        tbl.push_back(mk(1'b0, 4'h4, 2'd2, 6'd2, 4'h4, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h4, 2'd2, 6'd2, 4'h4, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h4, 2'd2, 6'd2, 4'h0, 4'h4, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 2'd2, 6'd2, 4'h4, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 2'd2, 6'd2, 4'h4, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 2'd2, 6'd2, 4'h0, 4'h4, 1'b0));
        // ch1, L=4, edges during ACTIVE ignored
        tbl.push_back(mk(1'b0, 4'h2, 2'd2, 6'd4, 4'h2, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 2'd2, 6'd4, 4'h2, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h2, 2'd2, 6'd4, 4'h2, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h2, 2'd2, 6'd4, 4'h2, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h2, 2'd2, 6'd4, 4'h0, 4'h2, 1'b0));
        // ch3, L=3; edge_sel=11 and stretch_len changes mid-pulse do not disturb it
        tbl.push_back(mk(1'b0, 4'hA, 2'd0, 6'd3,  4'h8, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hA, 2'd3, 6'd10, 4'h8, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hA, 2'd3, 6'd1,  4'h8, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hA, 2'd3, 6'd3,  4'h0, 4'h8, 1'b0));
        tbl.push_back(mk(1'b0, 4'h5, 2'd3, 6'd3,  4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 2'd3, 6'd3,  4'h0, 4'h0, 1'b0));
        // stretch_len=0 on all channels at once
        tbl.push_back(mk(1'b0, 4'hF, 2'd0, 6'd0, 4'hF, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hF, 2'd0, 6'd0, 4'h0, 4'hF, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 2'd0, 6'd0, 4'h0, 4'h0, 1'b0));
        // reset on 3rd pulse cycle, start_in held high through release
        tbl.push_back(mk(1'b0, 4'h1, 2'd0, 6'd6, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h1, 2'd0, 6'd6, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h1, 2'd0, 6'd6, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b1, 4'h1, 2'd0, 6'd6, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 2'd0, 6'd6, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h1, 2'd0, 6'd6, 4'h1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b1, 4'h1, 2'd0, 6'd6, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 2'd0, 6'd6, 4'h0, 4'h0, 1'b0));

        for (int i = 0; i < int'(tbl.size()); i++) begin
            drive(tbl[i].rst, tbl[i].sin, tbl[i].esel, tbl[i].len);
            chk("table", i, {out_a, done_a, busy_a}, {tbl[i].out, tbl[i].dn, tbl[i].bsy});
        end

        // RETRIG=1: L=6, second rising edge 4 cycles in keeps the pulse high 10 cycles
        drive(1'b1, 4'h0, 2'd0, 6'd6);
        drive(1'b1, 4'h0, 2'd0, 6'd6);
        drive(1'b0, 4'h0, 2'd0, 6'd6);
        for (int k = 0; k <= 10; k++) begin
            drive(1'b0, (k == 3) ? 4'h0 : 4'h1, 2'd0, 6'd6);
            chk("retrig", k, {out_r, done_r, busy_r}, {4'(k < 10), 4'(k == 10), (k < 10)});
        end
        // RETRIG=1: retrigger exactly on the last ACTIVE cycle, L=2
        drive(1'b0, 4'h0, 2'd0, 6'd2);
        for (int k = 0; k <= 4; k++) begin
            drive(1'b0, (k == 1) ? 4'h0 : 4'h1, 2'd0, 6'd2);
            chk("retrig_last", k, {out_r, done_r, busy_r}, {4'(k < 4), 4'(k == 4), (k < 4)});
        end

        // HOLDOFF_CYC=3: edge during holdoff ignored, edge on the return cycle accepted
        drive(1'b1, 4'h0, 2'd0, 6'd4);
        drive(1'b1, 4'h0, 2'd0, 6'd4);
        drive(1'b0, 4'h0, 2'd0, 6'd4);
        hpat = 13'b1111101011111;
        for (int k = 0; k <= 12; k++) begin
            drive(1'b0, {3'b000, hpat[k]}, 2'd0, 6'd4);
            chk("holdoff", k, {out_h, done_h, busy_h},
                {4'((k <= 3) || (k >= 8 && k <= 11)), 4'((k == 4) || (k == 12)),
                 ((k <= 6) || (k >= 8))});
        end
        // reset mid-HOLDOFF clears it; held start_in then triggers immediately
        drive(1'b1, 4'h1, 2'd0, 6'd4);
        chk("holdoff_rst", 0, {out_h, done_h, busy_h}, {4'h0, 4'h0, 1'b0});
        drive(1'b0, 4'h1, 2'd0, 6'd4);
        chk("holdoff_rst", 1, {out_h, done_h, busy_h}, {4'h1, 4'h0, 1'b1});
        drive(1'b1, 4'h0, 2'd0, 6'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
